ahb_bcd_formatter: RTL

AHB-Lite slave that converts a binary measurement from the CPU into the packed BCD display word consumed by the seven-segment display slave. The CPU writes a binary value together with mode and decimal-point fields. A sequential double-dabble engine produces three BCD digits. The CPU then reads back a word laid out exactly as the seven-segment register: [17:15] dp, [14:12] mode, [11:8] digit2, [7:4] digit1, [3:0] digit0. It sits on the same AHB-Lite bus, directly upstream of the seven-segment slave in the display path.

---
 rtl/ahb_bcd_formatter_if.sv | 22 ++
 rtl/ahb_bcd_formatter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ahb_bcd_formatter_if.sv
// AHB-Lite slave-side bus bundle for the BCD formatter.
interface ahb_bcd_formatter_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_bcd_formatter.sv
// AHB-Lite slave: binary operand to packed BCD display word via a
// sequential double-dabble engine (10 iterations, zero wait states).
module ahb_bcd_formatter (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahb_bcd_formatter_if.slave   ahb
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state;
  logic        write_en;
  logic        read_en;
  logic [1:0]  word_addr;

  logic [13:0] op_value;
  logic [2:0]  op_dp;
  logic [2:0]  op_mode;

  logic [9:0]  shift;
  logic [11:0] bcd;
  logic [3:0]  count;
  logic        busy;
  logic        overflow;
  logic [17:0] result;

  logic [11:0] bcd_adj;
  logic [11:0] bcd_next;
  logic [9:0]  shift_next;
  logic        capture;
  logic [31:0] rdata;
  logic        unused_bits;

  assign capture = write_en && (word_addr == 2'd0);

  // Add-3 on all nibbles from the pre-shift values, then one left shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcd_next   = {bcd_adj[10:0], shift[9]};
    shift_next = {shift[8:0], 1'b0};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      write_en  <= 1'b0;
      read_en   <= 1'b0;
      word_addr <= '0;
      op_value  <= '0;
      op_dp     <= '0;
      op_mode   <= '0;
      shift     <= '0;
      bcd       <= '0;
      count     <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      result    <= '0;
    end else begin
      if (ahb.HREADY && ahb.HSEL && (ahb.HTRANS != 2'b00)) begin
        write_en  <= ahb.HWRITE;
        read_en   <= !ahb.HWRITE;
        word_addr <= ahb.HADDR[3:2];
      end else begin
        write_en  <= 1'b0;
        read_en   <= 1'b0;
        word_addr <= '0;
      end

      // A new capture always wins over an in-flight iteration, including
      // the final one, so an abandoned conversion never reaches RESULT.
      if (capture) begin
        op_value <= ahb.HWDATA[13:0];
        op_dp    <= ahb.HWDATA[17:15];
        op_mode  <= ahb.HWDATA[20:18];
        if (ahb.HWDATA[13:0] <= 14'd999) begin
          state    <= CONV;
          shift    <= ahb.HWDATA[9:0];
          bcd      <= '0;
          count    <= '0;
          busy     <= 1'b1;
          overflow <= 1'b0;
        end else begin
          state    <= IDLE;
          result   <= {ahb.HWDATA[17:15], ahb.HWDATA[20:18], 12'hEEE};
          busy     <= 1'b0;
          overflow <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: ;
          CONV: begin
            shift <= shift_next;
            bcd   <= bcd_next;
            count <= count + 4'd1;
            if (count == 4'd9) begin
              result <= {op_dp, op_mode, bcd_next};
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (read_en) begin
      case (word_addr)
        2'd0:    rdata = {11'b0, op_mode, op_dp, 1'b0, op_value};
        2'd1:    rdata = {30'b0, overflow, busy};
        2'd2:    rdata = {14'b0, result};
        default: rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;

  assign unused_bits = ^{ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0],
                         ahb.HWDATA[31:21], ahb.HWDATA[14]};

endmodule
